// File: rtl/mac_tx_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_tx_frame_streamer                                        |
// | Description : Buffers one complete upstream frame, then replays it to the  |
// |               Triple-Speed MAC user TX interface. Handles MAC retransmit   |
// |               requests, drops on late collision / retry exhaustion /       |
// |               buffer overflow.                                             |
// | Options     : `define TX_PAD_EN to zero-pad short frames up to MIN_LEN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mac_tx_frame_streamer #(
  parameter int ADDR_W    = 11,
  parameter int MIN_LEN   = 60,
  parameter int MAX_RETRY = 15
) (
  input  logic       tx_mac_clk,
  input  logic       rstn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       in_error,
  output logic       in_ready,
  output logic       tx_mac_valid,
  output logic [7:0] tx_mac_data,
  output logic       tx_mac_last,
  output logic       tx_mac_error,
  input  logic       tx_mac_ready,
  input  logic       tx_collision,
  input  logic       tx_retransmit,
  output logic       frame_sent,
  output logic       frame_dropped,
  output logic       busy
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [ADDR_W-1:0]  c_ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]    c_LEN_ONE   = (ADDR_W + 1)'(1);
  localparam logic [RETRY_W-1:0] c_RETRY_ONE = RETRY_W'(1);
  localparam logic [RETRY_W-1:0] c_MAX_RETRY = RETRY_W'(MAX_RETRY);

  // LOAD is the single read-latency cycle at the start of SEND: it primes
  // the registered buffer read so byte 0 is ready when valid rises.
  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_DISCARD = 2'd1,
    S_LOAD    = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_len;
  logic [RETRY_W-1:0] r_retry;
  logic               r_err;
  logic [7:0]         r_mem [DEPTH];
  logic [7:0]         r_rdata;

  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  w_wr_ptr_nxt;
  logic [ADDR_W-1:0]  w_rd_ptr_nxt;
  logic [ADDR_W:0]    w_len_nxt;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic               w_err_nxt;
  logic               w_mem_we;
  logic               w_in_ready;
  logic               w_sent;
  logic               w_dropped;
  logic               w_clear;
  logic [ADDR_W:0]    w_tlen;
  logic [ADDR_W:0]    w_tlen_m1;
  logic               w_last;
  logic [7:0]         w_data;

`ifdef TX_PAD_EN
  localparam logic [ADDR_W:0] c_MIN_LEN = (ADDR_W + 1)'(MIN_LEN);
  logic w_pad;

  // Transmit length is stretched to MIN_LEN; bytes past the stored frame read as zero.
  always_comb begin
    w_tlen = (r_len < c_MIN_LEN) ? c_MIN_LEN : r_len;
    w_pad  = ({1'b0, r_rd_ptr} >= r_len);
    w_data = w_pad ? 8'h00 : r_rdata;
  end
`else
  // Frame goes out exactly as buffered.
  always_comb begin
    w_tlen = r_len;
    w_data = r_rdata;
  end
`endif

  assign w_tlen_m1 = w_tlen - c_LEN_ONE;
  assign w_last    = ({1'b0, r_rd_ptr} == w_tlen_m1);

  // Next-state / pointer logic; MAC pulses take priority over a MAC transfer.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_len_nxt    = r_len;
    w_retry_nxt  = r_retry;
    w_err_nxt    = r_err;
    w_mem_we     = 1'b0;
    w_in_ready   = 1'b0;
    w_sent       = 1'b0;
    w_dropped    = 1'b0;
    w_clear      = 1'b0;

    case (r_state)
      S_FILL: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_mem_we     = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + c_ADDR_ONE;
          w_err_nxt    = r_err | in_error;
          if (in_last) begin
            w_len_nxt   = {1'b0, r_wr_ptr} + c_LEN_ONE;
            w_state_nxt = S_LOAD;
          end else if (r_wr_ptr == {ADDR_W{1'b1}}) begin
            w_dropped   = 1'b1;
            w_state_nxt = S_DISCARD;
          end
        end
      end

      S_DISCARD: begin
        w_in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_clear = 1'b1;
        end
      end

      S_LOAD, S_SEND: begin
        if (tx_retransmit) begin
          if (r_retry < c_MAX_RETRY) begin
            w_retry_nxt  = r_retry + c_RETRY_ONE;
            w_rd_ptr_nxt = '0;
            w_state_nxt  = S_SEND;
          end else begin
            w_dropped = 1'b1;
            w_clear   = 1'b1;
          end
        end else if (tx_collision) begin
          w_dropped = 1'b1;
          w_clear   = 1'b1;
        end else if (r_state == S_LOAD) begin
          w_state_nxt = S_SEND;
        end else if (tx_mac_ready) begin
          if (w_last) begin
            w_sent  = 1'b1;
            w_clear = 1'b1;
          end else begin
            w_rd_ptr_nxt = r_rd_ptr + c_ADDR_ONE;
          end
        end
      end

      default: begin
        w_clear = 1'b1;
      end
    endcase

    if (w_clear) begin
      w_state_nxt  = S_FILL;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_len_nxt    = '0;
      w_retry_nxt  = '0;
      w_err_nxt    = 1'b0;
    end
  end

  // Control state; reset abandons any buffered frame silently.
  always_ff @(posedge tx_mac_clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_FILL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len    <= '0;
      r_retry  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_len    <= w_len_nxt;
      r_retry  <= w_retry_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Frame buffer: synchronous write, registered read addressed by the next read pointer.
  always_ff @(posedge tx_mac_clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= in_data;
    end
    r_rdata <= r_mem[w_rd_ptr_nxt];
  end

  assign in_ready      = w_in_ready;
  assign tx_mac_valid  = (r_state == S_SEND);
  assign tx_mac_data   = tx_mac_valid ? w_data : 8'h00;
  assign tx_mac_last   = tx_mac_valid & w_last;
  assign tx_mac_error  = tx_mac_valid & w_last & r_err;
  assign frame_sent    = w_sent;
  assign frame_dropped = w_dropped;
  assign busy          = (r_state != S_FILL);

endmodule
`default_nettype wire

// File: doc/mac_tx_frame_streamer.md
Name: mac_tx_frame_streamer

Overview:
- Client-side transmitter that feeds the Triple-Speed MAC user TX interface (tx_mac_valid/data/last/error/ready) on tx_mac_clk.
- Buffers one complete frame from an upstream byte stream, then replays it to the MAC.
- Restarts the frame on tx_retransmit. Drops the frame on late collision or retry exhaustion. Optionally pads short frames.

Parameters:
- ADDR_W, 11, frame buffer address width; buffer holds 2^ADDR_W bytes.
- MIN_LEN, 60, minimum frame length in bytes (excl. FCS) used by padding.
- MAX_RETRY, 15, retransmit attempts allowed before the frame is dropped.

Ports:
- tx_mac_clk  in  1  sole clock
- rstn  in  1  asynchronous active-low reset
- in_data  in  8  upstream frame byte
- in_valid  in  1  upstream byte valid
- in_last  in  1  upstream last byte of frame
- in_error  in  1  upstream error flag; sampled on any accepted byte
- in_ready  out  1  streamer accepts upstream byte
- tx_mac_valid  out  1  byte valid to MAC
- tx_mac_data  out  8  byte to MAC
- tx_mac_last  out  1  last byte of frame to MAC
- tx_mac_error  out  1  frame error to MAC; only asserted together with tx_mac_last
- tx_mac_ready  in  1  MAC accepts byte
- tx_collision  in  1  MAC collision pulse
- tx_retransmit  in  1  MAC retransmit request pulse
- frame_sent  out  1  one-cycle pulse: frame fully accepted by MAC
- frame_dropped  out  1  one-cycle pulse: frame discarded
- busy  out  1  high in any state other than FILL

Behaviour:
- Reset values:
  - All outputs 0, except in_ready = 1.
  - State FILL; write pointer, length, read pointer, retry count and sticky error all 0.
  - Reset mid-frame discards the buffer; no pulse is issued.
- Handshakes:
  - Upstream transfer when in_valid && in_ready.
  - MAC transfer when tx_mac_valid && tx_mac_ready.
  - While tx_mac_valid = 1 and tx_mac_ready = 0, data/last/error are held stable.
- FILL (in_ready = 1):
  - Each accepted byte is written at wr_ptr; wr_ptr increments.
  - in_error ORs into the sticky error flag.
  - Accepted byte with in_last: len = wr_ptr + 1, next state SEND.
  - Accepted byte without in_last at wr_ptr = 2^ADDR_W - 1 (overflow): frame_dropped pulse, next state DISCARD.
- DISCARD:
  - in_ready = 1; bytes are accepted and thrown away.
  - Accepted in_last: clear pointers and error, next state FILL.
- SEND (in_ready = 0):
  - tx_mac_valid = 1. tx_mac_data = buf[rd_ptr] while rd_ptr < len, else 0x00 (padding).
  - tx_mac_last = 1 when rd_ptr = tlen - 1, where tlen = max(len, MIN_LEN).
  - tx_mac_error = sticky error && tx_mac_last.
  - First byte is presented the cycle after entering SEND (1-cycle read latency allowed here only).
  - Transfer with last: frame_sent pulse, reset pointers/retry/error, next state FILL (in_ready = 1 the following cycle).
- Priority within a cycle:
  - tx_retransmit beats tx_collision beats a MAC transfer. A transfer in the same cycle as either pulse does not count.
- tx_retransmit in SEND:
  - retry < MAX_RETRY: retry += 1, rd_ptr = 0, stay in SEND; buffer is retained.
  - retry = MAX_RETRY: frame_dropped pulse, go to FILL with all pointers and the error flag cleared.
- tx_collision without tx_retransmit in SEND: frame_dropped pulse, go to FILL (cleared).
- Both MAC pulses are ignored in FILL and DISCARD.
- Widths:
  - rd_ptr, wr_ptr: ADDR_W bits. len, tlen: ADDR_W + 1 bits.
  - retry: $clog2(MAX_RETRY + 1) bits; it does not wrap.
- 1-byte frame: in_last on the first byte gives len = 1.

Optional Feature:
- TX_PAD_EN defined: short frames are zero-padded to MIN_LEN bytes as above.
- Undefined: tlen = len; no padding bytes are ever generated, and the padding mux and comparator are not synthesised.

Test Plan:
- 64-byte frame 0x00..0x3F, tx_mac_ready always 1 -> 64 MAC transfers in order; last on 0x3F; one frame_sent; tx_mac_error = 0.
- 10-byte frame with TX_PAD_EN -> 60 transfers, bytes 10..59 = 0x00, last on the 60th. Without TX_PAD_EN -> 10 transfers, last on the 10th.
- 100-byte frame, tx_retransmit after 20 transfers -> next transfer is byte 0; full 100 bytes follow; frame_sent once; retry count 1.
- 16 consecutive tx_retransmit pulses with MAX_RETRY = 15 -> frame_dropped on the 16th; in_ready = 1 the next cycle; no frame_sent.
- 2049 bytes without in_last (ADDR_W = 11) -> frame_dropped on byte 2048; bytes discarded until in_last; no MAC traffic; then a 64-byte frame passes normally.
- in_error on byte 5 of a 64-byte frame, with tx_mac_ready toggled 1/0 -> outputs held during stalls; tx_mac_error = 1 only on byte 63; rstn low mid-SEND -> tx_mac_valid = 0 immediately and in_ready = 1.
